// File: rtl/uart_tx_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo_pkg
//  Purpose  : Shared drain-FSM state encoding and special characters for the
//             uart_tx_fifo byte buffer.
//  Revision : 1.0  initial release
// ============================================================================
package uart_tx_fifo_pkg;

  // Drain FSM states; encodings are fixed so debug probes read consistently.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } tx_state_e;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage : uart_tx_fifo_pkg
`default_nettype wire

// File: rtl/uart_tx_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo_mem
//  Purpose  : Simple dual-port register array. Synchronous write, asynchronous
//             read so the top can load tx_data on the same edge it pops.
//             Contents are not reset; validity is tracked by the top's count.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo_mem #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] ram [2**DEPTH_LOG2];

  // Store the incoming byte at the write pointer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wr_addr] <= wr_data;
    end
  end

  assign rd_data = ram[rd_addr];

endmodule : uart_tx_fifo_mem
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Circular byte FIFO between uart_rx and uart_tx. Bytes arrive as
//             one-cycle write strobes and are drained one at a time through
//             the uart_tx start/ready handshake.
//  Options  : UART_TX_FIFO_CRLF_EN - when defined, an LF (8'h0A) is sent after
//             every CR (8'h0D) popped from the FIFO, without consuming a slot.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int BUSY_TMO   = 3
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wr,
  input  logic [7:0]          wr_data,
  input  logic                tx_ready,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_LOG2:0] count,
  output logic                overflow
);

  // Timeout counter only needs to reach BUSY_TMO-1.
  localparam int TMO_W = (BUSY_TMO < 2) ? 1 : $clog2(BUSY_TMO);

  localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(BUSY_TMO - 1);
  localparam logic [TMO_W-1:0]      TMO_ONE  = TMO_W'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  tx_state_e             state_q;
  tx_state_e             state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [7:0]            rd_data;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  push;
  logic                  pop;
  logic                  lf_load;

  // full/empty come from the occupancy count, never from pointer equality.
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);
  // A write on a full FIFO is dropped even if a pop happens on the same edge.
  assign push  = wr & ~full;

  uart_tx_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (8)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

`ifdef UART_TX_FIFO_CRLF_EN
  logic lf_pend;

  // LF goes out when the transmitter finishes the CR that armed it.
  assign lf_load = lf_pend & (state_q == DONE) & tx_ready;

  // Remember that a CR was popped until its trailing LF has been started.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lf_pend <= 1'b0;
    end else if (pop && (rd_data == CHAR_CR)) begin
      lf_pend <= 1'b1;
    end else if (lf_load) begin
      lf_pend <= 1'b0;
    end
  end
`else
  assign lf_load = 1'b0;
`endif

  // Drain FSM next-state logic; pop only from IDLE, never bypassing the FIFO.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && tx_ready) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        state_d = BUSY;
      end
      BUSY: begin
        if (!tx_ready) begin
          state_d = DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (tx_ready) begin
          state_d = lf_load ? START : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and registered one-cycle start pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      tx_start <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_start <= (state_d == START);
    end
  end

  // Counts cycles spent in BUSY waiting for tx_ready to fall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt <= '0;
    end else if (state_q == START) begin
      tmo_cnt <= '0;
    end else if (state_q == BUSY) begin
      tmo_cnt <= tmo_cnt + TMO_ONE;
    end
  end

  // Pointers, occupancy, sticky overflow and the outgoing byte register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (wr && full) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        tx_data <= rd_data;
      end else if (lf_load) begin
        tx_data <= CHAR_LF;
      end
    end
  end

endmodule : uart_tx_fifo
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Self-checking bench for uart_tx_fifo. A queue-based model of the
//             FIFO and of the transmitter handshake timeline is compared with
//             the DUT on every falling edge; directed scenarios add literal
//             checks on byte order, latency, overflow and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int BUSY_TMO   = 3;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk = 1'b0;
  logic                rstn = 1'b1;
  logic                wr = 1'b0;
  logic [7:0]          wr_data = 8'h00;
  logic                tx_ready = 1'b1;
  logic                tx_start;
  logic [7:0]          tx_data;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;

  uart_tx_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BUSY_TMO   (BUSY_TMO)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr       (wr),
    .wr_data  (wr_data),
    .tx_ready (tx_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mq   : bytes stored in the FIFO, oldest first
  // ph   : 0 transmitter free, 1 start cycle, 2 waiting for ready to fall,
  //        3 waiting for ready to return
  logic [7:0] mq[$];
  int         ph      = 0;
  int         k       = 0;
  bit         m_ovf   = 1'b0;
  bit         m_start = 1'b0;
  bit         lf_pend = 1'b0;
  logic [7:0] m_data  = 8'h00;
  int         cyc     = 0;
  bit         started = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      ph      = 0;
      k       = 0;
      m_ovf   = 1'b0;
      m_start = 1'b0;
      lf_pend = 1'b0;
      m_data  = 8'h00;
    end else begin
      bit was_full;
      cyc++;
      was_full = (mq.size() == DEPTH);
      case (ph)
        0: if (mq.size() > 0 && tx_ready) begin
             m_data = mq.pop_front();
             ph = 1;
`ifdef UART_TX_FIFO_CRLF_EN
             if (m_data == 8'h0D) lf_pend = 1'b1;
`endif
           end
        1: begin ph = 2; k = 0; end
        2: begin
             k++;
             if (!tx_ready) ph = 3;
             else if (k == BUSY_TMO) ph = 0;
           end
        default: if (tx_ready) begin
             if (lf_pend) begin
               lf_pend = 1'b0;
               m_data  = 8'h0A;
               ph      = 1;
             end else begin
               ph = 0;
             end
           end
      endcase
      if (wr) begin
        if (was_full) m_ovf = 1'b1;
        else          mq.push_back(wr_data);
      end
      m_start = (ph == 1);
    end
  end

  // ---------------- compare process ----------------
  logic [7:0] out_log[$];
  int         start_cyc[$];
  int         peak = 0;

  always @(negedge clk) begin
    if (started && rstn === 1'b1) begin
      chk("count",    32'(count),    32'(mq.size()));
      chk("empty",    32'(empty),    32'(mq.size() == 0));
      chk("full",     32'(full),     32'(mq.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("tx_start", 32'(tx_start), 32'(m_start));
      chk("tx_data",  32'(tx_data),  32'(m_data));
      if (tx_start === 1'b1) begin
        out_log.push_back(tx_data);
        start_cyc.push_back(cyc);
      end
      if (int'(count) > peak) peak = int'(count);
    end
  end

  // ---------------- stimulus helpers ----------------
  // txm: 0 = uart_tx model (ready low 20 cycles after start), 1 = ready held 0,
  //      2 = ready held 1
  int txm    = 0;
  int lowcnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    case (txm)
      0: begin
        if (tx_start === 1'b1) begin
          tx_ready = 1'b0;
          lowcnt   = 20;
        end else if (lowcnt > 0) begin
          lowcnt--;
          if (lowcnt == 0) tx_ready = 1'b1;
        end else begin
          tx_ready = 1'b1;
        end
      end
      1: tx_ready = 1'b0;
      default: tx_ready = 1'b1;
    endcase
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(mq.size() == 0 && ph == 0 && lowcnt == 0)) begin
      if (n >= budget) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: drain incomplete after %0d cycles, model holds %0d", tag, budget, mq.size());
        return;
      end
      tick();
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [7:0] exp_crlf[$];

    // Asynchronous reset before any clock edge.
    #2 rstn = 1'b0;
    #1;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'h00);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    tick();
    tick();
    #2 rstn = 1'b1;
    started = 1'b1;
    tick();

    // Single byte: pop one edge after the write, start pulse for one cycle.
    wr = 1'b1; wr_data = 8'h41;
    tick();
    wr = 1'b0;
    chk("single_cnt_after_wr", 32'(count),    32'd1);
    chk("single_no_bypass",    32'(tx_start), 32'd0);
    tick();
    chk("single_start",   32'(tx_start), 32'd1);
    chk("single_data",    32'(tx_data),  32'h41);
    chk("single_cnt0",    32'(count),    32'd0);
    chk("single_empty",   32'(empty),    32'd1);
    tick();
    chk("single_start_1cyc", 32'(tx_start), 32'd0);
    wait_idle(500, "single");
    chk("single_pulses", 32'(out_log.size()), 32'd1);

    // Burst of five bytes against the uart_tx model.
    out_log.delete();
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; wr_data = 8'(8'h31 + i);
      tick();
    end
    wr = 1'b0;
    wait_idle(2000, "burst");
    chk("burst_peak",     32'(peak),     32'd4);
    chk("burst_overflow", 32'(overflow), 32'd0);
    chk("burst_pulses",   32'(out_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < out_log.size(); i++)
      chk("burst_order", 32'(out_log[i]), 32'(8'h31 + i));

    // Overflow: 17 writes with the transmitter stalled.
    txm = 1;
    tick();
    out_log.delete();
    for (int i = 0; i < 17; i++) begin
      wr = 1'b1; wr_data = 8'(8'h50 + i);
      tick();
      if (i == 15) begin
        chk("ovf_full16",  32'(full),     32'd1);
        chk("ovf_not_yet", 32'(overflow), 32'd0);
      end
    end
    wr = 1'b0;
    chk("ovf_count", 32'(count),    32'd16);
    chk("ovf_full",  32'(full),     32'd1);
    chk("ovf_flag",  32'(overflow), 32'd1);
    txm = 0;
    wait_idle(3000, "overflow_drain");
    chk("ovf_drained", 32'(out_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < out_log.size(); i++)
      chk("ovf_order", 32'(out_log[i]), 32'(8'h50 + i));
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Timeout: ready never falls, next byte starts after BUSY_TMO cycles.
    txm = 2;
    tick();
    out_log.delete();
    start_cyc.delete();
    wr = 1'b1; wr_data = 8'hA0; tick();
    wr = 1'b1; wr_data = 8'hA1; tick();
    wr = 1'b0;
    wait_idle(200, "timeout");
    chk("tmo_pulses", 32'(start_cyc.size()), 32'd2);
    if (start_cyc.size() == 2)
      chk("tmo_gap", 32'(start_cyc[1] - start_cyc[0]), 32'd5);
    if (out_log.size() == 2) begin
      chk("tmo_b0", 32'(out_log[0]), 32'hA0);
      chk("tmo_b1", 32'(out_log[1]), 32'hA1);
    end

    // CR followed by a normal byte.
    txm = 0;
    tick();
    out_log.delete();
`ifdef UART_TX_FIFO_CRLF_EN
    exp_crlf = '{8'h0D, 8'h0A, 8'h42};
`else
    exp_crlf = '{8'h0D, 8'h42};
`endif
    wr = 1'b1; wr_data = 8'h0D; tick();
    wr = 1'b1; wr_data = 8'h42; tick();
    wr = 1'b0;
    wait_idle(500, "crlf");
    chk("crlf_len", 32'(out_log.size()), 32'(exp_crlf.size()));
    for (int i = 0; i < exp_crlf.size() && i < out_log.size(); i++)
      chk("crlf_seq", 32'(out_log[i]), 32'(exp_crlf[i]));

    // Reset mid-operation while BUSY with three bytes queued.
    txm = 2;
    tick();
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; wr_data = 8'(8'hC0 + i);
      tick();
    end
    wr = 1'b0;
    chk("mid_count3", 32'(count), 32'd3);
    #2 rstn = 1'b0;
    #1;
    out_log.delete();
    chk("mid_tx_start", 32'(tx_start), 32'd0);
    chk("mid_tx_data",  32'(tx_data),  32'h00);
    chk("mid_count",    32'(count),    32'd0);
    chk("mid_empty",    32'(empty),    32'd1);
    chk("mid_full",     32'(full),     32'd0);
    chk("mid_overflow", 32'(overflow), 32'd0);
    tick();
    tick();
    #2 rstn = 1'b1;
    txm = 0;
    repeat (30) tick();
    chk("mid_no_start", 32'(out_log.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_uart_tx_fifo
`default_nettype wire
